// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: scan controller for a 4-digit seven-segment (FND) display.
//
// Steps an active-low one-hot digit select from a prescaler tick. It takes
// new display contents through a valid/ready handshake into a pending buffer.
// Pending contents are committed to the active buffer only at frame boundaries
// (digit3 -> digit0), so a frame never mixes old and new data. Hex nibbles are
// decoded to active-low segments, with per-digit decimal points and optional
// leading-zero suppression.
//
// Optional feature macro: FND_DIMMING_EN
//   Adds i_brightness. The digit select is gated off for the tail of each
//   digit period. o_fnd_seg is not affected.
//
// Ports:
//   i_clk          system clock, posedge
//   i_reset_n      asynchronous active-low reset
//   i_valid        new display data offered
//   o_ready        pending buffer empty; transfer on i_valid && o_ready
//   i_value[15:0]  four hex nibbles, [3:0] = digit0 (rightmost)
//   i_dp[3:0]      per-digit decimal point, 1 = lit
//   i_lz_supp      leading-zero suppression, captured with i_value
//   i_brightness   (FND_DIMMING_EN only) 0..7, 7 = always on
//   o_fnd_sel[3:0] digit select, active-low one-hot
//   o_fnd_seg[7:0] segments {dp,g,f,e,d,c,b,a}, active-low
//   o_frame_done   one-cycle pulse aligned with the pin update to digit0

module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned CNT_W    = 17
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_lz_supp,
`ifdef FND_DIMMING_EN
    input  logic [2:0]  i_brightness,
`endif
    output logic [3:0]  o_fnd_sel,
    output logic [7:0]  o_fnd_seg,
    output logic        o_frame_done
);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
    } disp_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    disp_t            active;
    disp_t            pending;
    logic             ready_q;
    logic [3:0]       sel_q;
    logic [7:0]       seg_q;
    logic             frame_done_q;

    logic             tick;
    logic             boundary;
    logic             commit;
    logic [1:0]       idx_nxt;
    disp_t            src;
    logic [7:0]       seg_nxt;

    // Hex nibble to active-low a..g pattern (bit0 = a).
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Full segment byte for digit n, including blanking and decimal point.
    function automatic logic [7:0] digit_seg(input disp_t d, input logic [1:0] n);
        logic       z3;
        logic       z32;
        logic       z321;
        logic       blank;
        logic [3:0] nib;
        z3    = (d.value[15:12] == 4'h0);
        z32   = z3  && (d.value[11:8] == 4'h0);
        z321  = z32 && (d.value[7:4]  == 4'h0);
        nib   = d.value[{n, 2'b00} +: 4];
        blank = 1'b0;
        case (n)
            2'd3:    blank = d.lz && z3;
            2'd2:    blank = d.lz && z32;
            2'd1:    blank = d.lz && z321;
            default: blank = 1'b0;
        endcase
        return {~d.dp[n], (blank ? 7'h7F : hex_seg(nib))};
    endfunction

    // Tick, boundary and the data source for the next pin update.
    always_comb begin
        tick     = (cnt == CNT_W'(SCAN_DIV - 1));
        // The BLANK->SCAN tick is treated as a frame boundary.
        boundary = tick && ((state == ST_BLANK) || (idx == 2'd3));
        commit   = boundary && !ready_q;
        idx_nxt  = (state == ST_BLANK) ? 2'd0 : idx + 2'd1;
        // Committed data is shown starting with the digit0 slot it opens.
        src      = commit ? pending : active;
        seg_nxt  = digit_seg(src, idx_nxt);
    end

    // Scan state, prescaler, buffers and registered pin outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= 2'd0;
            active       <= '0;
            pending      <= '0;
            ready_q      <= 1'b1;
            sel_q        <= 4'hF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + CNT_W'(1);
            frame_done_q <= boundary;

            if (tick) begin
                state <= ST_SCAN;
                idx   <= idx_nxt;
                sel_q <= ~(4'b0001 << idx_nxt);
                seg_q <= seg_nxt;
            end

            // Commit requires a full buffer, so it never collides with a capture.
            if (commit) begin
                active  <= pending;
                ready_q <= 1'b1;
            end else if (i_valid && ready_q) begin
                pending <= '{value: i_value, dp: i_dp, lz: i_lz_supp};
                ready_q <= 1'b0;
            end
        end
    end

    assign o_ready      = ready_q;
    assign o_fnd_seg    = seg_q;
    assign o_frame_done = frame_done_q;

`ifdef FND_DIMMING_EN
    // Pins update at count 0, so the count is the position in the digit period.
    localparam int unsigned TH_W = CNT_W + 4;
    logic [TH_W-1:0] dim_prod;
    logic            dim_on;
    always_comb begin
        dim_prod = (TH_W'(i_brightness) + TH_W'(1)) * TH_W'(SCAN_DIV);
        dim_on   = TH_W'(cnt) < (dim_prod >> 3);
    end
    assign o_fnd_sel = dim_on ? sel_q : 4'hF;
`else
    assign o_fnd_sel = sel_q;
`endif

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV = 4.
module tb_fnd_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  fnd_sel;
    logic [7:0]  fnd_seg;
    logic        frame_done;
`ifdef FND_DIMMING_EN
    logic [2:0]  brightness;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] sels;
    logic [31:0] segs;

    localparam logic [15:0] SELS_EXP = 16'h7BDE;

    fnd_scan_ctrl #(.SCAN_DIV(4), .CNT_W(3)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_value      (value),
        .i_dp         (dp),
        .i_lz_supp    (lz),
`ifdef FND_DIMMING_EN
        .i_brightness (brightness),
`endif
        .o_fnd_sel    (fnd_sel),
        .o_fnd_seg    (fnd_seg),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge where o_frame_done is high (bounded).
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL wait_frame: no frame_done within %0d cycles", n);
        end
    endtask

    // Capture the four digit slots of the next frame, packed {d3,d2,d1,d0}.
    task automatic read_frame(output logic [15:0] s_sel, output logic [31:0] s_seg);
        wait_frame();
        s_sel[3:0] = fnd_sel;
        s_seg[7:0] = fnd_seg;
        for (int i = 1; i < 4; i++) begin
            repeat (4) @(negedge clk);
            s_sel[i*4 +: 4] = fnd_sel;
            s_seg[i*8 +: 8] = fnd_seg;
        end
    endtask

    // Offer one word for a single cycle, starting at a negedge.
    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic l);
        valid = 1'b1;
        value = v;
        dp    = d;
        lz    = l;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid   = 1'b0;
        value   = 16'h0;
        dp      = 4'h0;
        lz      = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fnd_sel !== 4'hF || fnd_seg !== 8'hFF || ready !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sel=%h seg=%h rdy=%b fd=%b want F FF 1 0",
                     fnd_sel, fnd_seg, ready, frame_done);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fnd_sel !== 4'hF || fnd_seg !== 8'hFF || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL blank_hold: sel=%h seg=%h fd=%b want F FF 0", fnd_sel, fnd_seg, frame_done);
        end
        @(negedge clk);
        checks++;
        if (fnd_sel !== 4'hE || fnd_seg !== 8'hC0 || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL first_tick: sel=%h seg=%h fd=%b want E C0 1", fnd_sel, fnd_seg, frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_width: fd=%b want 0", frame_done);
        end
    endtask

    task automatic test_basic();
        load(16'h1234, 4'h0, 1'b0);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_drop: rdy=%b want 0", ready);
        end
        read_frame(sels, segs);
        checks++;
        if (sels !== SELS_EXP || segs !== 32'hF9A4B099) begin
            failures++;
            $display("FAIL frame_1234: sel=%h seg=%h want %h F9A4B099", sels, segs, SELS_EXP);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_return: rdy=%b want 1", ready);
        end
    endtask

    task automatic test_lz_supp();
        load(16'h0007, 4'h0, 1'b1);
        read_frame(sels, segs);
        checks++;
        if (sels !== SELS_EXP || segs !== 32'hFFFFFFF8) begin
            failures++;
            $display("FAIL lz_0007: sel=%h seg=%h want %h FFFFFFF8", sels, segs, SELS_EXP);
        end
        load(16'h0000, 4'h0, 1'b1);
        read_frame(sels, segs);
        checks++;
        if (segs !== 32'hFFFFFFC0) begin
            failures++;
            $display("FAIL lz_0000: seg=%h want FFFFFFC0", segs);
        end
        load(16'h0105, 4'b0100, 1'b1);
        read_frame(sels, segs);
        checks++;
        if (segs !== 32'hFF79C092) begin
            failures++;
            $display("FAIL lz_0105_dp: seg=%h want FF79C092", segs);
        end
    endtask

    task automatic test_back_pressure();
        load(16'h000A, 4'h0, 1'b0);
        valid = 1'b1;
        value = 16'h000B;
        dp    = 4'h0;
        lz    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: rdy=%b want 0", ready);
        end
        wait_frame();
        checks++;
        if (fnd_seg !== 8'h88 || ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_a_first: seg=%h rdy=%b want 88 1", fnd_seg, ready);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_b_capture: rdy=%b want 0", ready);
        end
        read_frame(sels, segs);
        checks++;
        if (segs !== 32'hC0C0C083) begin
            failures++;
            $display("FAIL bp_b_frame: seg=%h want C0C0C083", segs);
        end
    endtask

    task automatic test_boundary_capture();
        // Ends inside the digit3 slot; three more cycles reach the boundary edge.
        repeat (3) @(negedge clk);
        valid = 1'b1;
        value = 16'h000C;
        dp    = 4'h0;
        lz    = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || fnd_seg !== 8'h83 || ready !== 1'b0) begin
            failures++;
            $display("FAIL bnd_no_bypass: fd=%b seg=%h rdy=%b want 1 83 0", frame_done, fnd_seg, ready);
        end
        read_frame(sels, segs);
        checks++;
        if (segs !== 32'hC0C0C0C6) begin
            failures++;
            $display("FAIL bnd_next_frame: seg=%h want C0C0C0C6", segs);
        end
    endtask

    task automatic test_reset_mid_frame();
        wait_frame();
        load(16'h000D, 4'h0, 1'b0);
        repeat (7) @(negedge clk);
        checks++;
        if (fnd_sel !== 4'hB || ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_setup: sel=%h rdy=%b want B 0", fnd_sel, ready);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fnd_sel !== 4'hF || fnd_seg !== 8'hFF || ready !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: sel=%h seg=%h rdy=%b fd=%b want F FF 1 0",
                     fnd_sel, fnd_seg, ready, frame_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        read_frame(sels, segs);
        checks++;
        if (sels !== SELS_EXP || segs !== 32'hC0C0C0C0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_discard: sel=%h seg=%h rdy=%b want %h C0C0C0C0 1",
                     sels, segs, ready, SELS_EXP);
        end
        read_frame(sels, segs);
        checks++;
        if (segs !== 32'hC0C0C0C0) begin
            failures++;
            $display("FAIL rst_discard2: seg=%h want C0C0C0C0", segs);
        end
    endtask

    initial begin
`ifdef FND_DIMMING_EN
        brightness = 3'd7;
`endif
        test_reset();
        test_basic();
        test_lz_supp();
        test_back_pressure();
        test_boundary_capture();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
